// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable DEPTH x 32 data memory with sized loads/stores and sign/zero extension.
// Latency: 1 cycle from request accept to registered response; a store is visible to the next accepted load.
// Backpressure: req_ready_o drops while a response is held unconsumed; DMEM_ERR_EN enables error reporting.
module dmem_lsu #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [31:0]       mem [DEPTH];
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic [ADDR_W-2:0] word_idx_ext;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wr_word;
    logic              wr_en;
    logic [31:0]       rd_word;
    logic [15:0]       rd_shift;
    logic [31:0]       ld_val;
    logic              misalign;
    logic              out_of_range;
    logic              chk_err;
    logic              err;

    assign req_ready_o  = rst_ni && (!rsp_valid_q || rsp_ready_i);
    assign accept       = req_valid_i && req_ready_o;
    assign word_idx_ext = {1'b0, req_addr_i[ADDR_W-1:2]};
    // Truncating the index gives modulo-DEPTH wrap; with checks enabled the out-of-range case is faulted anyway.
    assign word_idx     = word_idx_ext[IDX_W-1:0];
    assign out_of_range = (word_idx_ext >= (ADDR_W-1)'(DEPTH));
    assign rd_word      = mem[word_idx];

    always_comb begin
        lane     = 2'b00;
        misalign = 1'b0;
        case (req_size_i)
            SZ_BYTE: lane = req_addr_i[1:0];
            SZ_HALF: begin
                lane     = {req_addr_i[1], 1'b0};
                misalign = req_addr_i[0];
            end
            default: misalign = (req_addr_i[1:0] != 2'b00);
        endcase

        rd_shift = 16'(rd_word >> {lane, 3'b000});
        case (req_size_i)
            SZ_BYTE: begin
                be      = 4'b0001 << lane;
                wr_word = {4{req_wdata_i[7:0]}};
                ld_val  = {{24{!req_unsigned_i && rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_HALF: begin
                be      = 4'b0011 << lane;
                wr_word = {2{req_wdata_i[15:0]}};
                ld_val  = {{16{!req_unsigned_i && rd_shift[15]}}, rd_shift};
            end
            default: begin
                be      = 4'b1111;
                wr_word = req_wdata_i;
                ld_val  = rd_word;
            end
        endcase
    end

    assign chk_err = misalign || out_of_range || (req_size_i == SZ_RSVD);

`ifdef DMEM_ERR_EN
    assign err = chk_err;
`else
    logic unused_chk_err;
    assign unused_chk_err = chk_err;
    assign err            = 1'b0;
`endif

    assign wr_en = accept && req_we_i && !err;

    // Array contents survive reset; accept already requires rst_ni so nothing is written during reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (req_we_i || err) ? 32'd0 : ld_val;
            rsp_err_d   = err;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed plus random requests against a byte-array reference model of dmem_lsu.
module tb_dmem_lsu;
    localparam int DEPTH = 16;
    localparam int AW    = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [1:0]    req_size_i;
    logic          req_unsigned_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;

    dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  mem_m [4*DEPTH];
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [31:0] a_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses described by byte count and byte address.
    task automatic model(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int nb;
        int a;
        int base;
        logic [31:0] v;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a  = int'(addr);
`ifdef DMEM_ERR_EN
        er = (size == 2'd3) || (a % nb != 0) || (a / 4 >= DEPTH);
`else
        er = 1'b0;
`endif
        a    = a - (a % nb);
        base = ((a / 4) % DEPTH) * 4 + (a % 4);
        rd   = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(mem_m[base+i]) << (8*i));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wd;
    endtask

    task automatic req(input string tag, input logic we, input logic [AW-1:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
        int n = 0;
        drive(we, addr, size, uns, wd);
        #1;
        while (!req_ready_o && n < 16) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "/rdy"}, req_ready_o, 32'd1);
        @(posedge clk_i); #1;
        model(we, addr, size, uns, wd, exp_rd, exp_er);
        check({tag, "/vld"}, rsp_valid_o, 32'd1);
        check({tag, "/rdata"}, rsp_rdata_o, exp_rd);
        check({tag, "/err"}, rsp_err_o, exp_er);
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_size_i = 2'd0;
        req_unsigned_i = 1'b0; req_wdata_i = 32'd0; rsp_ready_i = 1'b1;

        #12;
        check("rst_vld", rsp_valid_o, 32'd0);
        check("rst_rdy", req_ready_o, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_err", rsp_err_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rel_rdy", req_ready_o, 32'd1);

        for (int i = 0; i < DEPTH; i++) req("init", 1'b1, AW'(i*4), 2'd2, 1'b0, $urandom);

        req("st_w", 1'b1, 8'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        req("ld_w", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0);
        check("plan_deadbeef", rsp_rdata_o, 32'hDEADBEEF);
        req("st_b", 1'b1, 8'h11, 2'd0, 1'b0, 32'h00000080);
        req("ld_bs", 1'b0, 8'h11, 2'd0, 1'b0, 32'd0);
        check("plan_bs", rsp_rdata_o, 32'hFFFFFF80);
        req("ld_bu", 1'b0, 8'h11, 2'd0, 1'b1, 32'd0);
        check("plan_bu", rsp_rdata_o, 32'h00000080);
        req("ld_w2", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0);
        check("plan_dead80ef", rsp_rdata_o, 32'hDEAD80EF);
        req("st_h", 1'b1, 8'h12, 2'd1, 1'b0, 32'h00001234);
        req("ld_hs", 1'b0, 8'h12, 2'd1, 1'b0, 32'd0);
        check("plan_hs", rsp_rdata_o, 32'h00001234);

        req("st_mis", 1'b1, 8'h11, 2'd2, 1'b0, 32'hCAFEF00D);
`ifdef DMEM_ERR_EN
        check("plan_mis_err", rsp_err_o, 32'd1);
        check("plan_mis_rdata", rsp_rdata_o, 32'd0);
        req("ld_after_mis", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0);
        check("plan_mis_kept", rsp_rdata_o, 32'h123480EF);
`else
        check("plan_mis_noerr", rsp_err_o, 32'd0);
        req("ld_after_mis", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0);
        check("plan_mis_landed", rsp_rdata_o, 32'hCAFEF00D);
`endif
        req("ld_oor", 1'b0, 8'h44, 2'd2, 1'b0, 32'd0);
        req("ld_rsvd", 1'b0, 8'h14, 2'd3, 1'b1, 32'd0);
        req("ld_hmis", 1'b0, 8'h13, 2'd1, 1'b0, 32'd0);

        // Backpressure: response A held while load B waits, then B follows in order.
        idle();
        rsp_ready_i = 1'b0;
        req("bp_a", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0);
        a_rd = exp_rd;
        drive(1'b0, 8'h11, 2'd0, 1'b0, 32'd0);
        repeat (3) begin
            @(posedge clk_i); #1;
            check("bp_rdy_low", req_ready_o, 32'd0);
            check("bp_vld_hold", rsp_valid_o, 32'd1);
            check("bp_rdata_hold", rsp_rdata_o, a_rd);
        end
        rsp_ready_i = 1'b1;
        #1;
        check("bp_rdy_release", req_ready_o, 32'd1);
        @(posedge clk_i); #1;
        model(1'b0, 8'h11, 2'd0, 1'b0, 32'd0, exp_rd, exp_er);
        check("bp_b_vld", rsp_valid_o, 32'd1);
        check("bp_b_rdata", rsp_rdata_o, exp_rd);
        check("bp_b_err", rsp_err_o, exp_er);
        idle();

        repeat (400) begin
            if ($urandom_range(3) == 0) idle();
            req("rnd", 1'($urandom_range(1)), AW'($urandom), 2'($urandom), 1'($urandom_range(1)), $urandom);
        end

        // Reset in the middle of a held response; memory must keep earlier stores.
        idle();
        req("st_keep", 1'b1, 8'h20, 2'd2, 1'b0, 32'hA5A55A5A);
        idle();
        rsp_ready_i = 1'b0;
        req("rst_ld", 1'b0, 8'h20, 2'd2, 1'b0, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_vld", rsp_valid_o, 32'd0);
        check("arst_rdata", rsp_rdata_o, 32'd0);
        check("arst_err", rsp_err_o, 32'd0);
        check("arst_rdy", req_ready_o, 32'd0);
        drive(1'b1, 8'h20, 2'd2, 1'b0, 32'h11111111);
        repeat (2) @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("arel_rdy", req_ready_o, 32'd1);
        rsp_ready_i = 1'b1;
        req("post_rst_ld", 1'b0, 8'h20, 2'd2, 1'b0, 32'd0);
        check("post_rst_kept", rsp_rdata_o, 32'hA5A55A5A);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressable 32-bit data memory with load/store sizing, a valid/ready request channel and a registered, back-pressurable response channel. It sits between the core's memory stage and on-chip data RAM. It replaces word-only, combinational-read storage with sub-word access, sign/zero extension, write byte enables and error reporting.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, 4..65536
- ADDR_W, 10, byte-address width; 4*DEPTH <= 2**ADDR_W
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high together with req_valid_i at a rising edge
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_W  byte address
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 reserved
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata_i  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o at a rising edge
- rsp_rdata_o  out  32  load result, extended; 0 for stores and errors
- rsp_err_o  out  1  request was misaligned, out of range or reserved size

## Operation
- Storage: DEPTH x 32 array. Word index = req_addr_i[ADDR_W-1:2]; lane = req_addr_i[1:0]. Contents are not reset.
- req_ready_o = rst_ni && (!rsp_valid_o || rsp_ready_i). Combinational; no dependency on req_valid_i.
- Accept (valid && ready at edge):
  - Store: write enabled bytes at that edge. Byte: lane k <- wdata[7:0]. Half: lanes {1,0} or {3,2} <- wdata[15:0]. Word: all lanes.
  - Load: read word and select lane(s) at that edge; extend to 32 bits per req_unsigned_i. req_unsigned_i is ignored for word loads.
  - In both cases, load the response register: rsp_valid_o <- 1 with rdata/err.
- Error conditions (checks active only when DMEM_ERR_EN is defined):
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - word index >= DEPTH
  - size 11
- On error, suppress the store, force rdata to 0 and set err to 1.
- Response register holds its value while rsp_valid_o && !rsp_ready_i. It clears to valid=0 on a consume edge with no new accept. On a consume + accept edge it reloads with the new response.
- At most one request is outstanding; the response order is the request order.

## Timing
- Load latency: 1 cycle, from the accept edge to rsp_valid_o high.
- Store visibility: a load accepted on the edge after a store's accept edge returns the new data. Back-to-back store then load, 1 cycle apart, is required to work.
- Throughput: 1 request per cycle while rsp_ready_i=1.
- Reset assert (asynchronous): rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and req_ready_o=0 immediately. Any pending response is dropped. No write occurs while rst_ni=0.
- Stores accepted before reset remain in the array.
- Reset deassert: req_ready_o=1 in the same cycle; the first accept is possible at the next rising edge.

## Configuration
- DMEM_ERR_EN defined:
  - All error checks are active, and rsp_err_o reports them.
  - Faulting stores leave memory unchanged.
- DMEM_ERR_EN undefined:
  - rsp_err_o is tied to 0.
  - Misaligned half/word requests are aligned down: addr[0] is ignored for half, addr[1:0] for word.
  - Out-of-range word index wraps modulo DEPTH.
  - Size 11 is treated as word.

## Test plan
- Store word 0xDEADBEEF @0x10; load word @0x10 on the next cycle -> rsp_rdata_o=0xDEADBEEF, err=0, 1-cycle latency.
- Store byte 0x80 @0x11, then:
  - signed load byte @0x11 -> 0xFFFFFF80
  - unsigned load byte @0x11 -> 0x00000080
  - word load @0x10 -> 0xDEAD80EF
- Store half 0x1234 @0x12; signed load half @0x12 -> 0x00001234.
- Misaligned store word @0x11 with DMEM_ERR_EN:
  - rsp_err_o=1 and rsp_rdata_o=0.
  - A follow-up load word @0x10 still returns the prior value.
  - Without the macro, the store lands at 0x10.
- Backpressure: hold rsp_ready_i=0 for 3 cycles after a load -> req_ready_o=0, response stable. Release -> the next queued load completes 1 cycle later, in order.
- Assert rst_ni mid-response -> rsp_valid_o drops to 0 without waiting for a clock. After release, the memory still holds the data stored before reset.
